// File: rtl/cc_sched_pkg.sv
// cc_sched_pkg: state encoding, RGB byte lanes and write-slot word selection for cc_sram_scheduler
package cc_sched_pkg;
  typedef enum logic [3:0] {IDLE, RD_Y, RD_U, RD_V, WAIT_RGB, WR0, WR1, WR2, FIN} state_t;
  localparam int LANE_R0 = 40;
  localparam int LANE_G0 = 32;
  localparam int LANE_B0 = 24;
  localparam int LANE_R1 = 16;
  localparam int LANE_G1 = 8;
  localparam int LANE_B1 = 0;
  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  function automatic logic [15:0] slot_word(input logic [47:0] d, input logic [1:0] s);
    return s == SLOT0 ? {d[LANE_R0+:8], d[LANE_G0+:8]} :
           s == SLOT1 ? {d[LANE_B0+:8], d[LANE_R1+:8]} :
                        {d[LANE_G1+:8], d[LANE_B1+:8]};
  endfunction
endpackage

// File: rtl/cc_addr_gen.sv
// cc_addr_gen: pair counter, RGB write pointer and segment address mux
module cc_addr_gen
  import cc_sched_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int PAIRS    = 38400,
  parameter int Y_BASE   = 0,
  parameter int U_BASE   = 38400,
  parameter int V_BASE   = 57600,
  parameter int RGB_BASE = 146944
) (
  input  logic              clk,
  input  logic              rst,
  input  state_t            state,
  input  logic              clr,
  input  logic              k_inc,
  input  logic              w_inc,
  output logic [ADDR_W-1:0] addr,
  output logic              k_zero,
  output logic              k_last
);
  logic [ADDR_W-1:0] k, wptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k    <= '0;
      wptr <= '0;
    end else begin
      k    <= clr ? '0 : k + ADDR_W'(k_inc);
      wptr <= clr ? '0 : wptr + ADDR_W'(w_inc);
    end
  assign k_zero = k == '0;
  assign k_last = k == ADDR_W'(PAIRS - 1);
  // WAIT_RGB presents the pending write address so the bus stays frozen while stalled
  always_comb
    addr = state == RD_Y ? ADDR_W'(Y_BASE) + k :
           state == RD_U ? ADDR_W'(U_BASE) + k :
           state == RD_V ? ADDR_W'(V_BASE) + k :
           state inside {WAIT_RGB, WR0, WR1, WR2} ? ADDR_W'(RGB_BASE) + wptr : '0;
endmodule

// File: rtl/cc_sram_scheduler.sv
// cc_sram_scheduler: SRAM read/write sequencer for YUV->RGB conversion; CC_SCHED_TIMEOUT_EN adds a WAIT_RGB stall timeout with sticky err
module cc_sram_scheduler
  import cc_sched_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int PAIRS    = 38400,
  parameter int Y_BASE   = 0,
  parameter int U_BASE   = 38400,
  parameter int V_BASE   = 57600,
  parameter int RGB_BASE = 146944
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rgb_valid,
  input  logic [47:0]       rgb_data,
  output logic              rgb_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n,
  output logic [15:0]       sram_wdata,
  output logic              y_ld,
  output logic              u_ld,
  output logic              v_ld,
  output logic              busy,
  output logic              end_of_pixel,
  output logic              done
`ifdef CC_SCHED_TIMEOUT_EN
  ,
  output logic              err
`endif
);
  state_t      state;
  logic [47:0] hold;
  logic        all_read, pending, k_zero, k_last;
`ifdef CC_SCHED_TIMEOUT_EN
  logic [7:0]  stall;
`endif
  assign rgb_ack = state == WAIT_RGB && rgb_valid;
  assign done    = end_of_pixel;
  cc_addr_gen #(
    .ADDR_W(ADDR_W), .PAIRS(PAIRS), .Y_BASE(Y_BASE),
    .U_BASE(U_BASE), .V_BASE(V_BASE), .RGB_BASE(RGB_BASE)
  ) u_addr (
    .clk(clk), .rst(rst), .state(state),
    .clr(state == IDLE && start),
    .k_inc(state == RD_V && !k_last),
    .w_inc(state inside {WR0, WR1, WR2}),
    .addr(sram_addr), .k_zero(k_zero), .k_last(k_last)
  );
  // pending marks the final pair, read but still waiting behind the previous pair's write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      hold         <= '0;
      all_read     <= 1'b0;
      pending      <= 1'b0;
      sram_we_n    <= 1'b1;
      sram_wdata   <= '0;
      y_ld         <= 1'b0;
      u_ld         <= 1'b0;
      v_ld         <= 1'b0;
      busy         <= 1'b0;
      end_of_pixel <= 1'b0;
`ifdef CC_SCHED_TIMEOUT_EN
      stall        <= '0;
      err          <= 1'b0;
`endif
    end else begin
      y_ld         <= state == RD_Y;
      u_ld         <= state == RD_U;
      v_ld         <= state == RD_V;
      end_of_pixel <= 1'b0;
`ifdef CC_SCHED_TIMEOUT_EN
      stall        <= '0;
`endif
      case (state)
        IDLE:
          if (start) begin
            state    <= RD_Y;
            busy     <= 1'b1;
            all_read <= 1'b0;
            pending  <= 1'b0;
`ifdef CC_SCHED_TIMEOUT_EN
            err      <= 1'b0;
`endif
          end
        RD_Y: state <= RD_U;
        RD_U: state <= RD_V;
        RD_V: begin
          state <= (k_zero && !k_last) ? RD_Y : WAIT_RGB;
          if (k_last) begin
            all_read <= 1'b1;
            pending  <= PAIRS > 1;
          end
        end
        WAIT_RGB:
          if (rgb_valid) begin
            hold       <= rgb_data;
            sram_we_n  <= 1'b0;
            sram_wdata <= slot_word(rgb_data, SLOT0);
            state      <= WR0;
`ifdef CC_SCHED_TIMEOUT_EN
          end else if (stall == 8'd254) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            stall <= stall + 8'd1;
`endif
          end
        WR0: begin
          sram_wdata <= slot_word(hold, SLOT1);
          state      <= WR1;
        end
        WR1: begin
          sram_wdata <= slot_word(hold, SLOT2);
          state      <= WR2;
        end
        WR2: begin
          sram_we_n <= 1'b1;
          if (!all_read) state <= RD_Y;
          else if (pending) begin
            pending <= 1'b0;
            state   <= WAIT_RGB;
          end else begin
            end_of_pixel <= 1'b1;
            state        <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cc_sram_scheduler.sv
// tb_cc_sram_scheduler: scoreboard bench with random RGB stalls/data against a frame-level transaction model
module tb_cc_sram_scheduler;
  localparam int AW = 18, P = 4, YB = 0, UB = 16, VB = 32, RB = 64;
  logic clk = 0, rst = 1, start = 0, rgb_valid = 0;
  logic [47:0] rgb_data = '0;
  logic rgb_ack, sram_we_n, y_ld, u_ld, v_ld, busy, end_of_pixel, done;
  logic [AW-1:0] sram_addr;
  logic [15:0] sram_wdata;
  logic start1 = 0, valid1 = 1;
  logic [47:0] data1 = 48'hA1B2C3D4E5F6;
  logic ack1, we1, y1, u1, v1, busy1, eop1, done1;
  logic [AW-1:0] addr1;
  logic [15:0] wd1;
`ifdef CC_SCHED_TIMEOUT_EN
  logic err, err1;
`endif
  cc_sram_scheduler #(.ADDR_W(AW), .PAIRS(P), .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB), .RGB_BASE(RB)) dut (
    .clk(clk), .rst(rst), .start(start), .rgb_valid(rgb_valid), .rgb_data(rgb_data),
    .rgb_ack(rgb_ack), .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_wdata(sram_wdata),
    .y_ld(y_ld), .u_ld(u_ld), .v_ld(v_ld), .busy(busy), .end_of_pixel(end_of_pixel), .done(done)
`ifdef CC_SCHED_TIMEOUT_EN
    , .err(err)
`endif
  );
  cc_sram_scheduler #(.ADDR_W(AW), .PAIRS(1), .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB), .RGB_BASE(RB)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rgb_valid(valid1), .rgb_data(data1),
    .rgb_ack(ack1), .sram_addr(addr1), .sram_we_n(we1), .sram_wdata(wd1),
    .y_ld(y1), .u_ld(u1), .v_ld(v1), .busy(busy1), .end_of_pixel(eop1), .done(done1)
`ifdef CC_SCHED_TIMEOUT_EN
    , .err(err1)
`endif
  );
  always #5 clk = ~clk;

  int checks = 0, errors = 0, dones = 0;
  logic [63:0] rdq[$], wrq[$];
  int lenq[$];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  function automatic logic [63:0] rd_ent(input int t, input int a);
    return {43'd0, 1'b1, 2'(t), AW'(a)};
  endfunction

  function automatic logic [63:0] wr_ent(input int a, input logic [15:0] d);
    return {29'd0, 1'b1, AW'(a), d};
  endfunction

  // monitor: reads are identified by the load strobe one cycle after the address
  initial begin
    logic [AW-1:0] pa;
    logic [63:0] obs;
    int cnt, e;
    pa = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (y_ld | u_ld | v_ld) begin
        obs = rd_ent(y_ld ? 0 : u_ld ? 1 : 2, int'(pa));
        chk("read", obs, rdq.size() ? rdq.pop_front() : 64'd0);
      end
      if (!sram_we_n) chk("write", wr_ent(int'(sram_addr), sram_wdata), wrq.size() ? wrq.pop_front() : 64'd0);
      if (busy) cnt++;
      if (done) begin
        dones++;
        chk("eop_with_done", end_of_pixel, 1);
        chk("queues_drained", rdq.size() + wrq.size(), 0);
        if (lenq.size()) begin
          e = lenq.pop_front();
          if (e > 0) chk("frame_len", cnt, e);
        end
      end
      if (!busy) cnt = 0;
      pa = sram_addr;
    end
  end

  // mode 0: rgb_valid always high; 1: ten stall cycles in the first WAIT_RGB; 2: random valid plus a mid-frame start
  task automatic frame(input int mode, input bit fin_start, input int rst_at);
    logic [47:0] pix[P];
    logic [AW-1:0] fa;
    int nack, d0;
    bit seen;
    nack = 0;
    d0 = dones;
    seen = 0;
    fa = '0;
    for (int j = 0; j < P; j++) pix[j] = {16'($urandom), 32'($urandom)};
    if (mode == 0) pix[0] = 48'h112233445566;
    for (int k = 0; k < P; k++) begin
      rdq.push_back(rd_ent(0, YB + k));
      rdq.push_back(rd_ent(1, UB + k));
      rdq.push_back(rd_ent(2, VB + k));
    end
    for (int j = 0; j < P; j++)
      for (int s = 0; s < 3; s++) wrq.push_back(wr_ent(RB + 3 * j + s, pix[j][47 - 16 * s -: 16]));
    lenq.push_back(mode == 0 ? 7 * P + 1 : mode == 1 ? 7 * P + 11 : 0);
    @(negedge clk);
    start = 1;
    for (int c = 1; c < 400 && !seen; c++) begin
      @(negedge clk);
      start = mode == 2 && c == 10;
      rgb_valid = mode == 0 ? 1'b1 : mode == 1 ? c > 16 : $urandom_range(0, 2) != 0;
      rgb_data = pix[nack < P ? nack : P - 1];
      if (mode == 1 && c == 7) fa = sram_addr;
      if (mode == 1 && c > 7 && c <= 17) begin
        chk("stall_addr_frozen", sram_addr, fa);
        chk("stall_we_n", sram_we_n, 1);
      end
      if (done) seen = 1;
      #1;
      if (rgb_ack) nack++;
      if (c == rst_at) begin
        rst = 1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_addr", sram_addr, 0);
        rdq.delete();
        wrq.delete();
        lenq.delete();
        @(negedge clk);
        rst = 0;
        return;
      end
    end
    chk("frame_done", seen, 1);
    if (fin_start) begin
      start = 1;
      @(negedge clk);
      start = 0;
      for (int i = 0; i < 3; i++) begin
        chk("fin_start_ignored", busy, 0);
        @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    chk("single_done", dones - d0, 1);
  endtask

  task automatic single_pair();
    logic [63:0] rd[$], wr[$];
    logic [AW-1:0] pa;
    int len;
    len = 0;
    pa = '0;
    @(negedge clk);
    start1 = 1;
    for (int c = 1; c < 40 && len == 0; c++) begin
      @(negedge clk);
      start1 = 0;
      if (y1 | u1 | v1) rd.push_back(rd_ent(y1 ? 0 : u1 ? 1 : 2, int'(pa)));
      if (!we1) wr.push_back(wr_ent(int'(addr1), wd1));
      if (done1) len = c;
      pa = addr1;
    end
    chk("p1_len", len, 8);
    chk("p1_nrd", rd.size(), 3);
    chk("p1_nwr", wr.size(), 3);
    if (rd.size() == 3 && wr.size() == 3) begin
      chk("p1_rd_y", rd[0], rd_ent(0, YB));
      chk("p1_rd_u", rd[1], rd_ent(1, UB));
      chk("p1_rd_v", rd[2], rd_ent(2, VB));
      chk("p1_wr0", wr[0], wr_ent(RB, 16'hA1B2));
      chk("p1_wr1", wr[1], wr_ent(RB + 1, 16'hC3D4));
      chk("p1_wr2", wr[2], wr_ent(RB + 2, 16'hE5F6));
    end
  endtask

`ifdef CC_SCHED_TIMEOUT_EN
  task automatic timeout_test();
    int c, d0;
    d0 = dones;
    for (int k = 0; k < 2; k++) begin
      rdq.push_back(rd_ent(0, YB + k));
      rdq.push_back(rd_ent(1, UB + k));
      rdq.push_back(rd_ent(2, VB + k));
    end
    rgb_valid = 0;
    @(negedge clk);
    start = 1;
    for (c = 1; c < 400; c++) begin
      @(negedge clk);
      start = 0;
      if (err) break;
    end
    chk("timeout_cycles", c, 6 + 255 + 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_done", dones - d0, 0);
    chk("timeout_reads", rdq.size(), 0);
    frame(0, 0, 0);
    chk("err_cleared", err, 0);
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_we_n", sram_we_n, 1);
    chk("reset_addr", sram_addr, 0);
    chk("reset_wdata", sram_wdata, 0);
    chk("reset_strobes", {y_ld, u_ld, v_ld, done, end_of_pixel, rgb_ack}, 0);
    rst = 0;
    @(negedge clk);
    frame(0, 1, 0);
    frame(1, 0, 0);
    for (int i = 0; i < 3; i++) frame(2, 0, 0);
    frame(0, 0, 12);
    frame(0, 0, 0);
    single_pair();
`ifdef CC_SCHED_TIMEOUT_EN
    timeout_test();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
